// File: rtl/mac_t_frame_loader_if.sv
// Egress loader bus: upstream byte stream plus the normal and TTE
// data/pointer FIFO write ports feeding the GMII TX MAC.
interface mac_t_frame_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_tte;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_dout;
  logic        data_fifo_full;
  logic        ptr_fifo_wr;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_full;
  logic        tdata_fifo_wr;
  logic [7:0]  tdata_fifo_dout;
  logic        tdata_fifo_full;
  logic        tptr_fifo_wr;
  logic [15:0] tptr_fifo_dout;
  logic        tptr_fifo_full;
  logic [15:0] frame_cnt;
  logic [15:0] trunc_cnt;

  modport slave (
    input  in_valid, in_data, in_last, in_tte,
    input  data_fifo_full, ptr_fifo_full,
    input  tdata_fifo_full, tptr_fifo_full,
    output in_ready,
    output data_fifo_wr, data_fifo_dout,
    output ptr_fifo_wr, ptr_fifo_dout,
    output tdata_fifo_wr, tdata_fifo_dout,
    output tptr_fifo_wr, tptr_fifo_dout,
    output frame_cnt, trunc_cnt
  );

  modport master (
    output in_valid, in_data, in_last, in_tte,
    output data_fifo_full, ptr_fifo_full,
    output tdata_fifo_full, tptr_fifo_full,
    input  in_ready,
    input  data_fifo_wr, data_fifo_dout,
    input  ptr_fifo_wr, ptr_fifo_dout,
    input  tdata_fifo_wr, tdata_fifo_dout,
    input  tptr_fifo_wr, tptr_fifo_dout,
    input  frame_cnt, trunc_cnt
  );
endinterface

// File: rtl/mac_t_frame_loader.sv
// Egress frame loader: pads runts, truncates oversize frames and
// writes one length/flag descriptor per frame into the normal or TTE FIFOs.
module mac_t_frame_loader #(
  parameter int          MIN_LEN   = 60,
  parameter int          MAX_LEN   = 1514,
  parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
  input logic           sys_clk,
  input logic           rst_sys,
  mac_t_frame_loader_if.slave bus
);

  localparam logic [10:0] MIN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_C = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_DROP,
    S_PTR
  } state_t;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic        dir_q;
  logic        hi_q;
  logic        ptp_q;
  logic        pad_q;
  logic        trunc_q;
  logic        wr_q;
  logic        twr_q;
  logic [7:0]  dout_q;
  logic        pwr_q;
  logic        tpwr_q;
  logic [15:0] desc_q;
  logic [15:0] fcnt_q;
  logic [15:0] tcnt_q;

  logic        dir;
  logic        dfull;
  logic        pfull;
  logic        rdy;
  logic        acc;
  logic [10:0] cnt_d;
  logic [15:0] desc_d;

  // Until the first byte is taken the class follows in_tte live.
  assign dir   = (state_q == S_IDLE) ? bus.in_tte : dir_q;
  assign dfull = dir ? bus.tdata_fifo_full : bus.data_fifo_full;
  assign pfull = dir ? bus.tptr_fifo_full : bus.ptr_fifo_full;

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      S_IDLE, S_DATA: rdy = !dfull;
      S_DROP:         rdy = 1'b1;
      default:        rdy = 1'b0;
    endcase
  end

  assign bus.in_ready = rdy && !rst_sys;
  assign acc    = bus.in_valid && bus.in_ready;
  assign cnt_d  = cnt_q + 11'd1;
  assign desc_d = {1'b0, trunc_q, pad_q, ptp_q, 1'b0, cnt_q};

  always_ff @(posedge sys_clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      hi_q    <= 1'b0;
      ptp_q   <= 1'b0;
      pad_q   <= 1'b0;
      trunc_q <= 1'b0;
      wr_q    <= 1'b0;
      twr_q   <= 1'b0;
      dout_q  <= '0;
      pwr_q   <= 1'b0;
      tpwr_q  <= 1'b0;
      desc_q  <= '0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      wr_q   <= 1'b0;
      twr_q  <= 1'b0;
      pwr_q  <= 1'b0;
      tpwr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DATA: begin
          if (acc) begin
            dir_q  <= dir;
            dout_q <= bus.in_data;
            wr_q   <= !dir;
            twr_q  <= dir;
            cnt_q  <= cnt_d;
            if (cnt_q == 11'd12)
              hi_q <= (bus.in_data == PTP_ETYPE[15:8]);
            if (cnt_q == 11'd13 && hi_q &&
                bus.in_data == PTP_ETYPE[7:0])
              ptp_q <= 1'b1;
            // in_last wins over the MAX_LEN cut
            if (bus.in_last)
              state_q <= (cnt_d < MIN_C) ? S_PAD : S_PTR;
            else if (cnt_d == MAX_C)
              state_q <= S_DROP;
            else
              state_q <= S_DATA;
          end
        end
        S_PAD: begin
          if (!dfull) begin
            dout_q <= 8'h00;
            wr_q   <= !dir_q;
            twr_q  <= dir_q;
            cnt_q  <= cnt_d;
            pad_q  <= 1'b1;
            if (cnt_d == MIN_C)
              state_q <= S_PTR;
          end
        end
        S_DROP: begin
          trunc_q <= 1'b1;
          if (acc && bus.in_last)
            state_q <= S_PTR;
        end
        S_PTR: begin
          if (!pfull) begin
            desc_q  <= desc_d;
            pwr_q   <= !dir_q;
            tpwr_q  <= dir_q;
            fcnt_q  <= fcnt_q + 16'd1;
            if (trunc_q)
              tcnt_q <= tcnt_q + 16'd1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            hi_q    <= 1'b0;
            ptp_q   <= 1'b0;
            pad_q   <= 1'b0;
            trunc_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_fifo_wr    = wr_q;
  assign bus.data_fifo_dout  = dout_q;
  assign bus.tdata_fifo_wr   = twr_q;
  assign bus.tdata_fifo_dout = dout_q;
  assign bus.ptr_fifo_wr     = pwr_q;
  assign bus.ptr_fifo_dout   = desc_q;
  assign bus.tptr_fifo_wr    = tpwr_q;
  assign bus.tptr_fifo_dout  = desc_q;
  assign bus.frame_cnt       = fcnt_q;
  assign bus.trunc_cnt       = tcnt_q;

endmodule

// File: tb/tb_mac_t_frame_loader.sv
// Scoreboard bench for mac_t_frame_loader: expected FIFO writes are
// queued as frames are driven and popped as the loader emits them.
module tb_mac_t_frame_loader;

  logic sys_clk = 1'b0;
  logic rst_sys;
  always #5 sys_clk = ~sys_clk;

  mac_t_frame_loader_if bus ();

  mac_t_frame_loader dut (
    .sys_clk (sys_clk),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  int          vec = 0;
  int          bad = 0;
  int          dq[$];
  int          pq[$];
  logic [7:0]  fb[0:1599];
  logic        tog_en = 1'b0;
  int          tog_n = 0;
  logic [15:0] last_desc = '0;
  int          me;
  logic [31:0] mo;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!tog_en) begin
      tog_n = 0;
      bus.data_fifo_full = 1'b0;
    end else begin
      tog_n++;
      if (tog_n % 3 == 0)
        bus.data_fifo_full = ~bus.data_fifo_full;
    end
  end

  always @(negedge sys_clk) begin
    if (!rst_sys) begin
      if (bus.data_fifo_wr || bus.tdata_fifo_wr) begin
        me = (dq.size() > 0) ? dq.pop_front() : -1;
        if (bus.data_fifo_wr && bus.tdata_fifo_wr)
          mo = 32'hDEAD;
        else if (bus.tdata_fifo_wr)
          mo = {23'd0, 1'b1, bus.tdata_fifo_dout};
        else
          mo = {24'd0, bus.data_fifo_dout};
        chk("data", mo, me);
      end
      if (bus.ptr_fifo_wr || bus.tptr_fifo_wr) begin
        chk("order", dq.size(), 0);
        me = (pq.size() > 0) ? pq.pop_front() : -1;
        if (bus.ptr_fifo_wr && bus.tptr_fifo_wr)
          mo = 32'hDEAD;
        else if (bus.tptr_fifo_wr)
          mo = {15'd0, 1'b1, bus.tptr_fifo_dout};
        else
          mo = {16'd0, bus.ptr_fifo_dout};
        chk("desc", mo, me);
        last_desc = bus.tptr_fifo_wr ?
          bus.tptr_fifo_dout : bus.ptr_fifo_dout;
      end
    end
  end

  // Reference model: truncate to 1514, pad to 60, build descriptor.
  task automatic model(input int n, input logic tte);
    int          w;
    int          len;
    logic [15:0] dsc;
    w = (n > 1514) ? 1514 : n;
    for (int i = 0; i < w; i++)
      dq.push_back(int'({23'd0, tte, fb[i]}));
    for (int i = w; i < 60; i++)
      dq.push_back(int'({23'd0, tte, 8'h00}));
    len = (w < 60) ? 60 : w;
    dsc = 16'(len);
    dsc[12] = (n >= 14) && (fb[12] == 8'h88) &&
              (fb[13] == 8'hF7);
    dsc[13] = (n < 60);
    dsc[14] = (n > 1514);
    pq.push_back(int'({15'd0, tte, dsc}));
  endtask

  task automatic put(input logic [7:0] d,
                     input logic last,
                     input logic tte);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_tte   = tte;
    n = 0;
    do begin
      ok = bus.in_ready;
      if (bus.data_fifo_full && !tte)
        chk("rdy_full", bus.in_ready, 0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok)
      chk("put_timeout", n, 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send(input int n, input logic tte);
    model(n, tte);
    @(negedge sys_clk);
    #1;
    for (int i = 0; i < n; i++)
      put(fb[i], (i == n - 1), tte);
  endtask

  task automatic wait_desc(input string tag);
    int n;
    n = 0;
    while (pq.size() > 0 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    #1;
    chk(tag, pq.size(), 0);
    chk({tag, "_dq"}, dq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_sys             = 1'b1;
    bus.in_valid        = 1'b0;
    bus.in_data         = '0;
    bus.in_last         = 1'b0;
    bus.in_tte          = 1'b0;
    bus.ptr_fifo_full   = 1'b0;
    bus.tdata_fifo_full = 1'b0;
    bus.tptr_fifo_full  = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_wr", {bus.data_fifo_wr, bus.tdata_fifo_wr,
                   bus.ptr_fifo_wr, bus.tptr_fifo_wr}, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_cnt", {bus.frame_cnt, bus.trunc_cnt}, 0);
    chk("rst_dout", {bus.data_fifo_dout,
                     bus.tdata_fifo_dout}, 0);
    chk("rst_pdout", {bus.ptr_fifo_dout,
                      bus.tptr_fifo_dout}, 0);
    rst_sys = 1'b0;

    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    send(64, 1'b0);
    wait_desc("t1");
    chk("t1_desc", last_desc, 16'h0040);
    chk("t1_fcnt", bus.frame_cnt, 1);

    for (int i = 0; i < 42; i++) fb[i] = 8'hA0 + 8'(i);
    fb[12] = 8'h88;
    fb[13] = 8'hF7;
    send(42, 1'b1);
    wait_desc("t2");
    chk("t2_desc", last_desc, 16'h303C);
    chk("t2_fcnt", bus.frame_cnt, 2);

    for (int i = 0; i < 1600; i++) fb[i] = 8'(i);
    send(1600, 1'b0);
    wait_desc("t3");
    chk("t3_desc", last_desc, 16'h45EA);
    chk("t3_tcnt", bus.trunc_cnt, 1);

    send(1514, 1'b0);
    wait_desc("t4");
    chk("t4_desc", last_desc, 16'h05EA);
    chk("t4_tcnt", bus.trunc_cnt, 1);

    for (int i = 0; i < 64; i++) fb[i] = 8'h55 ^ 8'(i);
    bus.ptr_fifo_full = 1'b1;
    tog_en = 1'b1;
    send(64, 1'b0);
    tog_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      #1;
      chk("t5_hold", bus.ptr_fifo_wr, 0);
    end
    bus.ptr_fifo_full = 1'b0;
    @(negedge sys_clk);
    #1;
    chk("t5_rel", bus.ptr_fifo_wr, 1);
    wait_desc("t5");
    chk("t5_desc", last_desc, 16'h0040);
    chk("t5_fcnt", bus.frame_cnt, 5);

    for (int i = 0; i < 60; i++) fb[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 30; i++)
      dq.push_back(int'({24'd0, fb[i]}));
    @(negedge sys_clk);
    #1;
    for (int i = 0; i < 30; i++) put(fb[i], 1'b0, 1'b0);
    repeat (3) @(negedge sys_clk);
    #1;
    chk("t6_pre", dq.size(), 0);
    rst_sys = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1;
    chk("t6_rcnt", bus.frame_cnt, 0);
    rst_sys = 1'b0;
    send(60, 1'b0);
    wait_desc("t6");
    chk("t6_desc", last_desc, 16'h003C);
    chk("t6_fcnt", bus.frame_cnt, 1);

    repeat (5) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
